fir_tdm_mac: RTL

//  Multi-channel FIR filter. One shared multiply-accumulate unit is time-multiplexed over all taps.

---
 rtl/fir_tdm_mac.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/fir_tdm_mac.sv
// Multi-channel FIR filter. One multiply-accumulate unit is shared by all taps and channels.
// Define FIR_SAT_EN to saturate the shifted result to DATA_W bits; otherwise it wraps.
module fir_tdm_mac #(
  parameter  int DATA_W    = 24,
  parameter  int COEF_W    = 16,
  parameter  int N_TAPS    = 61,
  parameter  int N_CHAN    = 2,
  parameter  int OUT_SHIFT = 15,
  localparam int CH_W      = (N_CHAN > 1) ? $clog2(N_CHAN) : 1,
  localparam int TAP_W     = $clog2(N_TAPS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_chan,
  input  logic [DATA_W-1:0] in_data,
  input  logic              coef_we,
  input  logic [TAP_W-1:0]  coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_chan,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + $clog2(N_TAPS);
  localparam logic [TAP_W:0]   N_TAPS_X = (TAP_W + 1)'(N_TAPS);
  localparam logic [CH_W:0]    N_CHAN_X = (CH_W + 1)'(N_CHAN);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(N_TAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_t;

  state_t                    state_q, state_d;
  logic [TAP_W-1:0]          tap_q, tap_d;
  logic [CH_W-1:0]           chan_q, chan_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;

  logic signed [COEF_W-1:0]  coef_q [N_TAPS];

  logic                      out_valid_q;
  logic [CH_W-1:0]           out_chan_q;
  logic [DATA_W-1:0]         out_data_q;

  logic                      chan_ok;
  logic                      sample_we;
  logic                      coef_wr;
  logic [N_CHAN-1:0][DATA_W-1:0] tap_sample;
  logic signed [DATA_W-1:0]  x_sel;
  logic signed [COEF_W-1:0]  c_sel;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   shifted;
  logic [DATA_W-1:0]         result;

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = ~in_ready;
  assign chan_ok   = ({1'b0, in_chan} < N_CHAN_X);
  // Out-of-range channels complete the handshake but are never stored or processed.
  assign sample_we = in_valid && in_ready && chan_ok;
  assign coef_wr   = coef_we && (state_q == S_IDLE) && ({1'b0, coef_addr} < N_TAPS_X);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N_TAPS; k++) begin
        coef_q[k] <= '0;
      end
    end else if (coef_wr) begin
      coef_q[coef_addr] <= coef_data;
    end
  end

  for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_chan
    logic [TAP_W-1:0]  wr_ptr_q;
    logic [DATA_W-1:0] hist_q [N_TAPS];
    logic [TAP_W:0]    back_x;
    logic [TAP_W-1:0]  rd_idx;

    // Tap k reads the sample k positions behind the newest one, modulo N_TAPS.
    always_comb begin
      if (wr_ptr_q >= tap_q) begin
        back_x = {1'b0, wr_ptr_q} - {1'b0, tap_q};
      end else begin
        back_x = {1'b0, wr_ptr_q} + N_TAPS_X - {1'b0, tap_q};
      end
    end

    assign rd_idx         = back_x[TAP_W-1:0];
    assign tap_sample[gi] = hist_q[rd_idx];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr_q <= '0;
        for (int k = 0; k < N_TAPS; k++) begin
          hist_q[k] <= '0;
        end
      end else begin
        if (sample_we && (in_chan == CH_W'(gi))) begin
          hist_q[wr_ptr_q] <= in_data;
        end
        if ((state_q == S_OUT) && (chan_q == CH_W'(gi))) begin
          wr_ptr_q <= (wr_ptr_q == LAST_TAP) ? '0 : wr_ptr_q + 1'b1;
        end
      end
    end
  end

  assign x_sel    = $signed(tap_sample[chan_q]);
  assign c_sel    = coef_q[tap_q];
  assign prod     = PROD_W'(x_sel) * PROD_W'(c_sel);
  assign prod_ext = ACC_W'(prod);
  assign shifted  = acc_q >>> OUT_SHIFT;

`ifdef FIR_SAT_EN
  logic fits;
  assign fits   = (&shifted[ACC_W-1:DATA_W-1]) | ~(|shifted[ACC_W-1:DATA_W-1]);
  assign result = fits ? shifted[DATA_W-1:0]
                : (shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                    : {1'b0, {(DATA_W-1){1'b1}}});
`else
  assign result = shifted[DATA_W-1:0];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      tap_q   <= '0;
      chan_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      chan_q  <= chan_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    chan_d  = chan_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: begin
        if (sample_we) begin
          state_d = S_MAC;
          tap_d   = '0;
          chan_d  = in_chan;
          acc_d   = '0;
        end
      end
      S_MAC: begin
        acc_d = acc_q + prod_ext;
        if (tap_q == LAST_TAP) begin
          state_d = S_OUT;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      S_OUT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The result is registered on the edge that leaves OUT, so out_valid lands in the following IDLE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= (state_q == S_OUT);
      if (state_q == S_OUT) begin
        out_chan_q <= chan_q;
        out_data_q <= result;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign out_data  = out_data_q;

endmodule
